// File: rtl/vga_frame_reader_if.sv
// Framebuffer read port plus line-buffer stream port for vga_frame_reader.
// The reader is the master on both: it issues reads and sources stream words.
interface vga_frame_reader_if #(
  parameter int RGB_SIZE = 12,
  parameter int AW       = 19
);
  logic                mem_req;
  logic [AW-1:0]       mem_addr;
  logic [RGB_SIZE-1:0] mem_rdata;
  logic                mem_rvld;
  logic [RGB_SIZE:0]   line_buffer_data;
  logic                line_buffer_vld;
  logic                line_buffer_rdy;

  modport master (
    output mem_req, mem_addr,
    input  mem_rdata, mem_rvld,
    output line_buffer_data, line_buffer_vld,
    input  line_buffer_rdy
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_rdata, mem_rvld,
    input  line_buffer_data, line_buffer_vld,
    output line_buffer_rdy
  );
endinterface

// File: rtl/vga_frame_reader.sv
// Raster-order framebuffer scan-out: credit-limited reads into a small FIFO,
// streamed out with a start-of-frame flag in the word MSB.
module vga_frame_reader #(
  parameter int RGB_SIZE   = 12,
  parameter int H_DISPLAY  = 640,
  parameter int V_DISPLAY  = 480,
  parameter int AW         = 19,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          enable,
  input  logic [AW-1:0] fb_base,
  output logic          busy,
  vga_frame_reader_if.master bus
);
  localparam int XW = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1;
  localparam int YW = (V_DISPLAY > 1) ? $clog2(V_DISPLAY) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(RD_LATENCY + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_DISPLAY - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_DISPLAY - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic [IW-1:0]         quiet_q;
  logic [RD_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [RD_LATENCY-1:0] sof_sr_q, sof_sr_d;
  logic [RGB_SIZE:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  issue, sof_issue, push, pop, head_vld;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    issue      = (state_q == RUN) && ((int'(count_q) + int'(inflight_q)) < FIFO_DEPTH);
    sof_issue  = issue && (x_q == '0) && (y_q == '0);
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          addr_d  = fb_base;
          x_d     = '0;
          y_d     = '0;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d = '0;
              // Frame boundary is the only place enable and fb_base take effect.
              if (enable) addr_d = fb_base;
              else        state_d = IDLE;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Pushes come from the request-side shift register, never raw mem_rvld,
  // so returns for reads issued before a reset are dropped.
  always_comb begin
    vld_sr_d   = RD_LATENCY'({vld_sr_q, issue});
    sof_sr_d   = RD_LATENCY'({sof_sr_q, sof_issue});
    push       = vld_sr_q[RD_LATENCY-1];
    head_vld   = (count_q != '0);
    pop        = head_vld && bus.line_buffer_rdy;
    count_d    = count_q;
    inflight_d = inflight_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    unique case ({issue, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= '0;
      quiet_q    <= IW'(RD_LATENCY);
      vld_sr_q   <= '0;
      sof_sr_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
      vld_sr_q   <= vld_sr_d;
      sof_sr_q   <= sof_sr_d;
      count_q    <= count_d;
      if (quiet_q != '0) quiet_q <= quiet_q - 1'b1;
      if (push)          wptr_q  <= wptr_q + 1'b1;
      if (pop)           rptr_q  <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem_q[wptr_q] <= {sof_sr_q[RD_LATENCY-1], bus.mem_rdata};
  end

  assign bus.mem_req          = issue;
  assign bus.mem_addr         = addr_q;
  assign bus.line_buffer_vld  = head_vld;
  assign bus.line_buffer_data = head_vld ? fifo_mem_q[rptr_q] : '0;
  assign busy                 = (state_q == RUN) || (inflight_q != '0) || (count_q != '0);

  // Stragglers from before a reset are tolerated for one read latency.
  assert property (@(posedge sys_clk) disable iff (sys_rst)
    (quiet_q == '0) |-> (bus.mem_rvld == vld_sr_q[RD_LATENCY-1]));
  assert property (@(posedge sys_clk) disable iff (sys_rst)
    !(push && !pop && (count_q == CW'(FIFO_DEPTH))));
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a 4x2 frame with a 2-cycle memory model;
// every stream word and request address is checked against hand-derived values.
module tb_vga_frame_reader;
  localparam int RGB = 12;
  localparam int H   = 4;
  localparam int V   = 2;
  localparam int AW  = 8;
  localparam int L   = 2;
  localparam int D   = 4;
  localparam int NPX = H * V;

  typedef struct {
    int           cyc;
    logic [RGB:0] val;
  } event_t;

  logic          clock  = 1'b0;
  logic          reset  = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] fbBase = '0;
  logic          lbRdy  = 1'b0;
  logic          randRdy = 1'b0;
  logic          busy;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  event_t        reqQ[$];
  event_t        outQ[$];
  logic [RGB:0]  expQ[$];
  logic          reqPipe  [L];
  logic [AW-1:0] addrPipe [L];

  vga_frame_reader_if #(.RGB_SIZE(RGB), .AW(AW)) bus ();

  vga_frame_reader #(
    .RGB_SIZE(RGB), .H_DISPLAY(H), .V_DISPLAY(V), .AW(AW),
    .RD_LATENCY(L), .FIFO_DEPTH(D)
  ) dut (
    .sys_clk (clock),
    .sys_rst (reset),
    .enable  (enable),
    .fb_base (fbBase),
    .busy    (busy),
    .bus     (bus)
  );

  function automatic logic [RGB-1:0] pixel(input logic [AW-1:0] a);
    return {4'hC, a};
  endfunction

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Fixed-latency memory: every request returns exactly L cycles later.
  always @(posedge clock) begin
    reqPipe[0]  <= bus.mem_req;
    addrPipe[0] <= bus.mem_addr;
    for (int i = 1; i < L; i++) begin
      reqPipe[i]  <= reqPipe[i-1];
      addrPipe[i] <= addrPipe[i-1];
    end
  end
  assign bus.mem_rvld        = reqPipe[L-1];
  assign bus.mem_rdata       = pixel(addrPipe[L-1]);
  assign bus.line_buffer_rdy = lbRdy;

  always @(negedge clock) begin
    if (!reset && bus.mem_req) reqQ.push_back(event_t'{cyc, (RGB+1)'(bus.mem_addr)});
    if (!reset && bus.line_buffer_vld && lbRdy) outQ.push_back(event_t'{cyc, bus.line_buffer_data});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] base, input logic en);
    fbBase = base;
    enable = en;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
    if (randRdy) lbRdy = 1'($urandom_range(0, 1));
  endtask

  task automatic clearQueues();
    reqQ.delete();
    outQ.delete();
    expQ.delete();
  endtask

  task automatic waitReqs(input int n, input int limit);
    int k = 0;
    while (reqQ.size() < n && k < limit) begin
      tick();
      k++;
    end
    if (reqQ.size() < n) checkOutput("timeout_reqs", reqQ.size(), n);
  endtask

  task automatic waitWords(input int n, input int limit);
    int k = 0;
    while (outQ.size() < n && k < limit) begin
      tick();
      k++;
    end
    if (outQ.size() < n) checkOutput("timeout_words", outQ.size(), n);
  endtask

  task automatic waitIdle(input string tag, input int limit);
    int k = 0;
    while (busy !== 1'b0 && k < limit) begin
      tick();
      k++;
    end
    checkOutput({tag, "_busy_idle"}, busy, 0);
    checkOutput({tag, "_req_idle"}, bus.mem_req, 0);
  endtask

  task automatic expectFrame(input logic [AW-1:0] base);
    for (int i = 0; i < NPX; i++)
      expQ.push_back({(i == 0), pixel(base + AW'(i))});
  endtask

  task automatic checkReqs(input string tag, input int n,
                           input logic [AW-1:0] b0, input logic [AW-1:0] b1, input logic [AW-1:0] b2);
    logic [AW-1:0] bases [3];
    bases = '{b0, b1, b2};
    checkOutput({tag, "_req_count"}, reqQ.size(), n);
    for (int i = 0; i < reqQ.size() && i < n; i++)
      checkOutput($sformatf("%s_addr%0d", tag, i), reqQ[i].val, bases[i / NPX] + AW'(i % NPX));
  endtask

  task automatic compareStream(input string tag);
    checkOutput({tag, "_word_count"}, outQ.size(), expQ.size());
    for (int i = 0; i < outQ.size() && i < expQ.size(); i++)
      checkOutput($sformatf("%s_word%0d", tag, i), outQ[i].val, expQ[i]);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c0;
    int sofs;
    int hold;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_vld",  bus.line_buffer_vld, 0);
    checkOutput("rst_data", bus.line_buffer_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req",  bus.mem_req, 0);
    checkOutput("rst_addr", bus.mem_addr, 0);
    reset = 1'b0;
    tick();

    // Single frame at 0x10, sink always ready
    $display("[TB] single frame");
    clearQueues();
    lbRdy = 1'b1;
    applyStimulus(8'h10, 1'b1);
    c0 = cyc;
    tick();
    applyStimulus(8'h10, 1'b0);
    waitIdle("t1", 100);
    checkReqs("t1", NPX, 8'h10, 8'h10, 8'h10);
    if (reqQ.size() == NPX && outQ.size() > 0) begin
      checkOutput("t1_first_req",  reqQ[0].cyc - c0, 1);
      checkOutput("t1_req_span",   reqQ[NPX-1].cyc - reqQ[0].cyc, NPX - 1);
      checkOutput("t1_first_word", outQ[0].cyc - reqQ[0].cyc, L + 1);
    end
    expectFrame(8'h10);
    compareStream("t1");

    // Back-to-back frames, base switched mid-frame
    $display("[TB] base switch");
    clearQueues();
    applyStimulus(8'h10, 1'b1);
    waitReqs(3, 50);
    applyStimulus(8'h40, 1'b1);
    waitReqs(NPX + 2, 50);
    applyStimulus(8'h40, 1'b0);
    waitIdle("t2", 100);
    checkReqs("t2", 2 * NPX, 8'h10, 8'h40, 8'h40);
    if (reqQ.size() == 2 * NPX)
      checkOutput("t2_req_span", reqQ[2*NPX-1].cyc - reqQ[0].cyc, 2 * NPX - 1);
    expectFrame(8'h10);
    expectFrame(8'h40);
    compareStream("t2");

    // Sink stall for 10 cycles mid-frame
    $display("[TB] sink stall");
    clearQueues();
    applyStimulus(8'h20, 1'b1);
    tick();
    applyStimulus(8'h20, 1'b0);
    waitWords(2, 50);
    lbRdy = 1'b0;
    repeat (10) tick();
    hold = outQ.size();
    checkOutput("t3_req_stall", bus.mem_req, 0);
    checkOutput("t3_buffered",  reqQ.size() - hold, D);
    checkOutput("t3_head_vld",  bus.line_buffer_vld, 1);
    checkOutput("t3_head_data", bus.line_buffer_data, {1'b0, pixel(8'h20 + AW'(hold))});
    lbRdy = 1'b1;
    waitIdle("t3", 100);
    checkReqs("t3", NPX, 8'h20, 8'h20, 8'h20);
    expectFrame(8'h20);
    compareStream("t3");

    // Random backpressure over three frames
    $display("[TB] random ready");
    clearQueues();
    randRdy = 1'b1;
    applyStimulus(8'h10, 1'b1);
    waitReqs(1, 50);
    applyStimulus(8'h30, 1'b1);
    waitReqs(NPX + 1, 200);
    applyStimulus(8'h50, 1'b1);
    waitReqs(2 * NPX + 1, 200);
    applyStimulus(8'h50, 1'b0);
    waitIdle("t4", 500);
    randRdy = 1'b0;
    lbRdy = 1'b1;
    checkReqs("t4", 3 * NPX, 8'h10, 8'h30, 8'h50);
    expectFrame(8'h10);
    expectFrame(8'h30);
    expectFrame(8'h50);
    compareStream("t4");
    sofs = 0;
    foreach (outQ[i]) if (outQ[i].val[RGB]) sofs++;
    checkOutput("t4_sof_count", sofs, 3);

    // Reset with FIFO words and reads in flight
    $display("[TB] reset mid-frame");
    clearQueues();
    lbRdy = 1'b0;
    applyStimulus(8'h10, 1'b1);
    tick();
    applyStimulus(8'h10, 1'b0);
    waitReqs(4, 50);
    checkOutput("t5_pre_vld", bus.line_buffer_vld, 1);
    reset = 1'b1;
    tick();
    checkOutput("t5_rst_vld",  bus.line_buffer_vld, 0);
    checkOutput("t5_rst_data", bus.line_buffer_data, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_req",  bus.mem_req, 0);
    checkOutput("t5_rst_addr", bus.mem_addr, 0);
    reset = 1'b0;
    repeat (4) tick();
    checkOutput("t5_late_drop", bus.line_buffer_vld, 0);
    clearQueues();
    lbRdy = 1'b1;
    applyStimulus(8'h60, 1'b1);
    tick();
    applyStimulus(8'h60, 1'b0);
    waitIdle("t5", 100);
    checkReqs("t5", NPX, 8'h60, 8'h60, 8'h60);
    expectFrame(8'h60);
    compareStream("t5");

    // Enable dropped at pixel 3: frame still completes
    $display("[TB] enable drop mid-frame");
    clearQueues();
    applyStimulus(8'h70, 1'b1);
    waitReqs(3, 50);
    applyStimulus(8'h70, 1'b0);
    waitIdle("t6", 100);
    repeat (5) tick();
    checkReqs("t6", NPX, 8'h70, 8'h70, 8'h70);
    expectFrame(8'h70);
    compareStream("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
